rwm_sequencer: RTL
==================

RWM_SEQUENCER -- requirements
Module: rwm_sequencer

Interface
REQ-001 Parameter N, default 2, image height in pixels.
REQ-002 Parameter M, default 2, image width in pixels; frame length L = 3*N*M bytes.
REQ-003 Parameter TIMEOUT, default 1024, maximum cycles from operation launch to RWM_done.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle command from the top-level controller to run one frame.
REQ-007 cam_sof  in  1  camera start-of-frame pulse; first byte is on data_in the following cycle.
REQ-008 RWM_done  in  1  completion status from the R/W memory.
REQ-009 RWM_valid  in  1  read-data-valid from the R/W memory.
REQ-010 RWM_enable  out  1  operation launch strobe to the R/W memory.
REQ-011 rw  out  1  1 = write, 0 = read; held stable for a whole operation.
REQ-012 clear  out  1  clear request; held stable for a whole clear operation.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 frame_done  out  1  one-cycle pulse when a frame completes cleanly.
REQ-015 error  out  1  sticky fault flag.
REQ-016 frame_count  out  8  number of clean frames completed, wraps 255 -> 0.

Function
REQ-017 The block SHALL implement states IDLE, CLR, SOF_WAIT, WR, RD, FIN and ERR.
REQ-018 IDLE: start=1 -> CLR when RWM_SEQ_AUTOCLEAR_EN is defined, otherwise -> SOF_WAIT.
REQ-019 CLR: on entry, RWM_enable=1 for exactly one cycle, with clear=1 held until RWM_done; RWM_done -> SOF_WAIT.
REQ-020 SOF_WAIT: cam_sof=1 -> WR. On the same cycle that cam_sof is seen, RWM_enable=1 (one cycle) and rw=1, so that the memory enters WRITE when the first byte arrives.
REQ-021 WR: rw=1 is held; RWM_done -> RD. On that transition, RWM_enable=1 (one cycle) with rw=0.
REQ-022 RD: a 16-bit counter increments on every cycle with RWM_valid=1. RWM_done with count==L-1 or count==L -> FIN; RWM_done with any other count -> ERR.
REQ-023 FIN: frame_done=1 and frame_count increments, both for exactly one cycle; FIN -> IDLE.
REQ-024 ERR: error=1 and it remains set; only start=1 clears error and restarts the sequence as in IDLE.
REQ-025 RWM_enable SHALL never be high for two consecutive cycles, and SHALL never be high in IDLE, FIN or ERR.
REQ-026 Watchdog: a counter clears on each operation launch and increments in CLR/WR/RD; if it reaches TIMEOUT before RWM_done -> ERR.
REQ-027 SOF_WAIT SHALL NOT time out; it waits indefinitely for the camera.
REQ-028 start while busy SHALL be ignored in every state except ERR; it does not queue.
REQ-029 cam_sof outside SOF_WAIT SHALL be ignored.
REQ-030 RWM_done in IDLE, SOF_WAIT, FIN or ERR SHALL be ignored.
REQ-031 If RWM_done and the watchdog limit occur on the same cycle, RWM_done wins.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst=1 SHALL force state IDLE, all outputs 0, frame_count=0 and all counters=0 on the next edge, including mid-operation.
REQ-034 When rst deasserts, the first start is accepted.

Configuration
REQ-035 Macro RWM_SEQ_AUTOCLEAR_EN defined: each frame begins with the CLR step.
REQ-036 Macro undefined: the CLR state is not compiled in, clear is tied to 0, and IDLE goes directly to SOF_WAIT.

Verification
REQ-037 N=M=2, clean frame: start, cam_sof after 5 cycles, memory model reads 12 bytes -> three single-cycle RWM_enable pulses (two without AUTOCLEAR), frame_done once, frame_count=1.
REQ-038 Short read: model asserts RWM_done after 7 RWM_valid cycles -> error=1, no frame_done; next start clears error.
REQ-039 TIMEOUT=16, model never returns RWM_done in WR -> ERR entered exactly 16 cycles after launch.
REQ-040 start pulsed in SOF_WAIT, WR and RD -> no extra launch; frame_count increments by exactly 1.
REQ-041 rst asserted in RD for 1 cycle -> all outputs 0 next edge; a subsequent start runs a full clean frame.
REQ-042 256 clean frames -> frame_count wraps to 0, and frame_done is seen 256 times.

Source files
------------

// File: rtl/rwm_sequencer.sv
// Frame sequencer: launches clear/write/read operations on an R/W memory for one camera frame.
// Defining RWM_SEQ_AUTOCLEAR_EN adds a memory-clear step (CLR state) at the start of every frame.
module rwm_sequencer #(
    parameter int N       = 2,
    parameter int M       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cam_sof,
    input  logic       RWM_done,
    input  logic       RWM_valid,
    output logic       RWM_enable,
    output logic       rw,
    output logic       clear,
    output logic       busy,
    output logic       frame_done,
    output logic       error,
    output logic [7:0] frame_count,
    output logic [2:0] state_dbg
);
    localparam int L    = 3 * N * M;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     LEN_LO  = 16'(L - 1);
    localparam logic [15:0]     LEN_HI  = 16'(L);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SOF_WAIT = 3'd1,
        WR       = 3'd2,
        RD       = 3'd3,
        FIN      = 3'd4,
`ifdef RWM_SEQ_AUTOCLEAR_EN
        ERR      = 3'd5,
        CLR      = 3'd6
`else
        ERR      = 3'd5
`endif
    } state_t;

    // Memory handshake: RWM_enable is a one-cycle launch with rw/clear held for the whole
    // operation; the memory answers with one RWM_done (and RWM_valid per byte on reads).
    // A done coinciding with our own launch strobe is stale and belongs to the previous op.
    state_t            state_q, state_d;
    logic              enable_q, enable_d;
    logic              rw_q, rw_d;
    logic              clear_q, clear_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              error_q, error_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              op_done;
    logic              wdog_hit;

    always_comb begin
        state_d       = state_q;
        enable_d      = 1'b0;
        rw_d          = rw_q;
        clear_d       = clear_q;
        frame_done_d  = 1'b0;
        error_d       = error_q;
        frame_count_d = frame_count_q;
        rd_cnt_d      = rd_cnt_q;
        wdog_d        = wdog_q;
        op_done       = RWM_done && !enable_q;
        wdog_hit      = (wdog_q == WD_LAST);

        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    error_d  = 1'b0;
                    rd_cnt_d = '0;
                    wdog_d   = '0;
                    rw_d     = 1'b0;
`ifdef RWM_SEQ_AUTOCLEAR_EN
                    state_d  = CLR;
                    enable_d = 1'b1;
                    clear_d  = 1'b1;
`else
                    state_d  = SOF_WAIT;
`endif
                end
            end
`ifdef RWM_SEQ_AUTOCLEAR_EN
            CLR: begin
                wdog_d = wdog_q + 1'b1;
                if (op_done) begin
                    clear_d = 1'b0;
                    state_d = SOF_WAIT;
                end else if (wdog_hit) begin
                    clear_d = 1'b0;
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
`endif
            SOF_WAIT: begin
                if (cam_sof) begin
                    enable_d = 1'b1;
                    rw_d     = 1'b1;
                    wdog_d   = '0;
                    state_d  = WR;
                end
            end
            WR: begin
                wdog_d = wdog_q + 1'b1;
                if (op_done) begin
                    enable_d = 1'b1;
                    rw_d     = 1'b0;
                    wdog_d   = '0;
                    rd_cnt_d = '0;
                    state_d  = RD;
                end else if (wdog_hit) begin
                    rw_d    = 1'b0;
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
            RD: begin
                wdog_d = wdog_q + 1'b1;
                if (RWM_valid) rd_cnt_d = rd_cnt_q + 16'd1;
                // The last byte may or may not be counted before done, so accept L-1 or L.
                if (op_done) begin
                    if (rd_cnt_q == LEN_LO || rd_cnt_q == LEN_HI) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        state_d       = FIN;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERR;
                    end
                end else if (wdog_hit) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            rw_q          <= 1'b0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            frame_count_q <= 8'd0;
            rd_cnt_q      <= 16'd0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            rw_q          <= rw_d;
            clear_q       <= clear_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
            rd_cnt_q      <= rd_cnt_d;
            wdog_q        <= wdog_d;
        end
    end

    assign RWM_enable  = enable_q;
    assign rw          = rw_q;
    assign clear       = clear_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign error       = error_q;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;
endmodule
